// File: rtl/sudoku_constraint_tracker.sv
// sudoku_constraint_tracker: row/col/box digit bitmaps for a 9x9 board.
// Serves CHECK/PLACE/REMOVE/CLEAR with fixed latency to the solver FSM.
module sudoku_constraint_tracker #(
  parameter int N     = 9,
  parameter int CNT_W = 7
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Cmd_valid,
  output logic             Cmd_ready,
  input  logic [1:0]       Cmd_op,
  input  logic [3:0]       Row,
  input  logic [3:0]       Col,
  input  logic [3:0]       Value,
  output logic             Rsp_valid,
  output logic             Ok,
  output logic             Err,
  output logic [N-1:0]     Used_mask,
  output logic [CNT_W-1:0] Placed_count
);

  localparam int MAX_CNT = N * N;

  localparam logic [1:0] OP_CHECK  = 2'b00;
  localparam logic [1:0] OP_PLACE  = 2'b01;
  localparam logic [1:0] OP_REMOVE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_CLR
  } state_t;

  state_t state, state_n;

  logic [1:0] op_q;
  logic [3:0] row_q, col_q, val_q;
  logic [3:0] box_q, idx_q;
  logic       err_q;

  logic [N-1:0] row_mask [N];
  logic [N-1:0] col_mask [N];
  logic [N-1:0] box_mask [N];

  logic [1:0]   rdiv, cdiv;
  logic [3:0]   box_d;
  logic         err_d;
  logic [3:0]   row_i, col_i;
  logic [N-1:0] bit_v, rm, cm, bm, any_m;
  logic         absent, present;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    Cmd_ready = 1'b0;
    unique case (state)
      S_IDLE: begin
        Cmd_ready = 1'b1;
        if (Cmd_valid)
          state_n = (Cmd_op == OP_CLEAR) ? S_CLR : S_DECODE;
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC:   state_n = S_IDLE;
      S_CLR:    if (idx_q == 4'd9) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // divide by 3 via compares; box = r*3 + c as r + 2r + c
  assign rdiv  = (row_q < 4'd3) ? 2'd0 :
                 (row_q < 4'd6) ? 2'd1 : 2'd2;
  assign cdiv  = (col_q < 4'd3) ? 2'd0 :
                 (col_q < 4'd6) ? 2'd1 : 2'd2;
  assign box_d = {2'b00, rdiv} + {1'b0, rdiv, 1'b0}
               + {2'b00, cdiv};
  assign err_d = (row_q > 4'd8) | (col_q > 4'd8)
               | (val_q == 4'd0) | (val_q > 4'd9);

  assign row_i = (row_q > 4'd8) ? 4'd0 : row_q;
  assign col_i = (col_q > 4'd8) ? 4'd0 : col_q;
  assign bit_v = {{(N-1){1'b0}}, 1'b1} << (val_q - 4'd1);

  assign rm      = row_mask[row_i];
  assign cm      = col_mask[col_i];
  assign bm      = box_mask[box_q];
  assign any_m   = rm | cm | bm;
  assign absent  = ((any_m & bit_v) == '0);
  assign present = (|(rm & bit_v)) && (|(cm & bit_v))
                && (|(bm & bit_v));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < N; i++) begin
        row_mask[i] <= '0;
        col_mask[i] <= '0;
        box_mask[i] <= '0;
      end
      op_q         <= '0;
      row_q        <= '0;
      col_q        <= '0;
      val_q        <= '0;
      box_q        <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      Rsp_valid    <= 1'b0;
      Ok           <= 1'b0;
      Err          <= 1'b0;
      Used_mask    <= '0;
      Placed_count <= '0;
    end else begin
      Rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (Cmd_valid) begin
            op_q  <= Cmd_op;
            row_q <= Row;
            col_q <= Col;
            val_q <= Value;
            idx_q <= '0;
          end
        end
        S_DECODE: begin
          box_q <= box_d;
          err_q <= err_d;
        end
        S_EXEC: begin
          Rsp_valid <= 1'b1;
          if (err_q) begin
            Ok  <= 1'b0;
            Err <= 1'b1;
          end else begin
            Err       <= 1'b0;
            Ok        <= 1'b0;
            Used_mask <= any_m;
            unique case (1'b1)
              (op_q == OP_CHECK): Ok <= absent;
              (op_q == OP_PLACE): begin
                if (absent) begin
                  row_mask[row_i] <= rm | bit_v;
                  col_mask[col_i] <= cm | bit_v;
                  box_mask[box_q] <= bm | bit_v;
                  Used_mask       <= any_m | bit_v;
                  Ok              <= 1'b1;
                  if (Placed_count < CNT_W'(MAX_CNT))
                    Placed_count <= Placed_count + CNT_W'(1);
                end
              end
              (op_q == OP_REMOVE): begin
                // partial presence is left untouched
                if (present) begin
                  row_mask[row_i] <= rm & ~bit_v;
                  col_mask[col_i] <= cm & ~bit_v;
                  box_mask[box_q] <= bm & ~bit_v;
                  Used_mask       <= any_m & ~bit_v;
                  Ok              <= 1'b1;
                  if (Placed_count != '0)
                    Placed_count <= Placed_count - CNT_W'(1);
                end
              end
              default: ;
            endcase
          end
        end
        S_CLR: begin
          if (idx_q == 4'd9) begin
            Rsp_valid    <= 1'b1;
            Ok           <= 1'b1;
            Err          <= 1'b0;
            Used_mask    <= '0;
            Placed_count <= '0;
          end else begin
            row_mask[idx_q] <= '0;
            col_mask[idx_q] <= '0;
            box_mask[idx_q] <= '0;
            idx_q           <= idx_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_constraint_tracker.sv
// tb_sudoku_constraint_tracker: table vectors, corner sequences and
// random commands against a digit-set model of the board constraints.
module tb_sudoku_constraint_tracker;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Cmd_valid;
  logic       Cmd_ready;
  logic [1:0] Cmd_op;
  logic [3:0] Row, Col, Value;
  logic       Rsp_valid, Ok, Err;
  logic [8:0] Used_mask;
  logic [6:0] Placed_count;

  always #5 Clk = ~Clk;

  sudoku_constraint_tracker #(.N(9), .CNT_W(7)) dut (
    .Clk(Clk), .Reset(Reset),
    .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready),
    .Cmd_op(Cmd_op), .Row(Row), .Col(Col), .Value(Value),
    .Rsp_valid(Rsp_valid), .Ok(Ok), .Err(Err),
    .Used_mask(Used_mask), .Placed_count(Placed_count)
  );

  localparam int CHK = 0, PLC = 1, REM = 2, CLR = 3;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // model: which digits each row, column and box holds
  bit   rh [9][10];
  bit   ch [9][10];
  bit   bh [9][10];
  int   m_cnt;
  logic [8:0] m_mask;

  function automatic void m_reset();
    for (int i = 0; i < 9; i++)
      for (int d = 0; d < 10; d++) begin
        rh[i][d] = 0; ch[i][d] = 0; bh[i][d] = 0;
      end
    m_cnt  = 0;
    m_mask = '0;
  endfunction

  function automatic void m_step(input int op, r, c, v,
                                 output bit ok, err,
                                 output int lat);
    int b;
    bit ir, ic, ib;
    lat = 2; ok = 0; err = 0;
    if (op == CLR) begin
      m_reset();
      ok  = 1;
      lat = 10;
      return;
    end
    if (r > 8 || c > 8 || v < 1 || v > 9) begin
      err = 1;
      return;
    end
    b  = (r / 3) * 3 + c / 3;
    ir = rh[r][v]; ic = ch[c][v]; ib = bh[b][v];
    case (op)
      CHK: ok = !(ir || ic || ib);
      PLC: if (!(ir || ic || ib)) begin
        rh[r][v] = 1; ch[c][v] = 1; bh[b][v] = 1;
        if (m_cnt < 81) m_cnt++;
        ok = 1;
      end
      REM: if (ir && ic && ib) begin
        rh[r][v] = 0; ch[c][v] = 0; bh[b][v] = 0;
        if (m_cnt > 0) m_cnt--;
        ok = 1;
      end
      default: ;
    endcase
    m_mask = '0;
    for (int d = 1; d <= 9; d++)
      if (rh[r][d] || ch[c][d] || bh[b][d]) m_mask[d-1] = 1'b1;
  endfunction

  task automatic drive(input int op, r, c, v,
                       output int lat, output int busy);
    int w = 0;
    while (!Cmd_ready && w < 20) begin
      @(posedge Clk); #1;
      w++;
    end
    if (!Cmd_ready) chk("ready wait", 0, 1);
    Cmd_valid = 1'b1;
    Cmd_op    = 2'(op);
    Row       = 4'(r);
    Col       = 4'(c);
    Value     = 4'(v);
    @(posedge Clk); #1;
    Cmd_valid = 1'b0;
    busy = Cmd_ready ? 0 : 1;
    lat  = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clk); #1;
      if (Rsp_valid) begin
        lat = k;
        break;
      end
      if (!Cmd_ready) busy++;
      // busy: inputs must be ignored
      Cmd_valid = 1'($urandom);
      Cmd_op    = 2'($urandom);
      Row       = 4'($urandom);
      Col       = 4'($urandom);
      Value     = 4'($urandom);
    end
    Cmd_valid = 1'b0;
  endtask

  task automatic run(input string tag, input int op, r, c, v,
                     input bit eok, eerr, input int ecnt,
                     input logic [8:0] emask, input int elat);
    int lat, busy;
    drive(op, r, c, v, lat, busy);
    chk({tag, " latency"}, lat, elat);
    chk({tag, " busy"}, busy, elat);
    chk({tag, " ok"}, int'(Ok), int'(eok));
    chk({tag, " err"}, int'(Err), int'(eerr));
    chk({tag, " count"}, int'(Placed_count), ecnt);
    chk({tag, " mask"}, int'(Used_mask), int'(emask));
    @(posedge Clk); #1;
    chk({tag, " strobe"}, int'(Rsp_valid), 0);
    chk({tag, " ok hold"}, int'(Ok), int'(eok));
    chk({tag, " err hold"}, int'(Err), int'(eerr));
  endtask

  task automatic run_model(input string tag, input int op, r, c, v);
    bit eok, eerr;
    int elat;
    m_step(op, r, c, v, eok, eerr, elat);
    run(tag, op, r, c, v, eok, eerr, m_cnt, m_mask, elat);
  endtask

  typedef struct {
    int         op, r, c, v;
    bit         ok, err;
    int         cnt;
    logic [8:0] mask;
  } vec_t;

  typedef struct { int r, c, v; } cell_t;

  vec_t  tab [13];
  cell_t placed [$];

  initial begin
    bit   dok, derr;
    int   dlat, sel, op, r, c, v, seen;

    tab[0]  = '{PLC, 0, 0, 5,  1, 0, 1, 9'h010};
    tab[1]  = '{CHK, 0, 8, 5,  0, 0, 1, 9'h010};
    tab[2]  = '{CHK, 8, 0, 5,  0, 0, 1, 9'h010};
    tab[3]  = '{CHK, 2, 2, 5,  0, 0, 1, 9'h010};
    tab[4]  = '{CHK, 4, 4, 5,  1, 0, 1, 9'h000};
    tab[5]  = '{PLC, 1, 1, 5,  0, 0, 1, 9'h010};
    tab[6]  = '{REM, 0, 0, 5,  1, 0, 0, 9'h000};
    tab[7]  = '{PLC, 1, 1, 5,  1, 0, 1, 9'h010};
    tab[8]  = '{PLC, 9, 0, 3,  0, 1, 1, 9'h010};
    tab[9]  = '{PLC, 3, 3, 0,  0, 1, 1, 9'h010};
    tab[10] = '{PLC, 3, 3, 10, 0, 1, 1, 9'h010};
    tab[11] = '{REM, 4, 4, 5,  0, 0, 1, 9'h000};
    tab[12] = '{REM, 1, 5, 5,  0, 0, 1, 9'h010};

    Reset = 1'b0; Cmd_valid = 1'b0; Cmd_op = '0;
    Row = '0; Col = '0; Value = '0;
    m_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("reset ready", int'(Cmd_ready), 1);
    chk("reset count", int'(Placed_count), 0);
    chk("reset mask", int'(Used_mask), 0);
    chk("reset rsp", int'(Rsp_valid), 0);
    chk("reset ok", int'(Ok), 0);
    chk("reset err", int'(Err), 0);
    Reset = 1'b1;
    @(posedge Clk); #1;

    for (int i = 0; i < 13; i++) begin
      m_step(tab[i].op, tab[i].r, tab[i].c, tab[i].v, dok, derr, dlat);
      run($sformatf("vec%0d", i), tab[i].op, tab[i].r, tab[i].c,
          tab[i].v, tab[i].ok, tab[i].err, tab[i].cnt, tab[i].mask, 2);
    end

    run_model("fill0", PLC, 2, 6, 2);
    run_model("fill1", PLC, 4, 0, 7);
    run_model("fill2", PLC, 5, 5, 9);
    run_model("fill3", PLC, 7, 8, 3);
    run_model("fill4", PLC, 8, 4, 1);
    run("clear", CLR, 0, 0, 0, 1, 0, 0, 9'h000, 10);
    m_reset();
    run("post clr a", CHK, 1, 1, 5, 1, 0, 0, 9'h000, 2);
    run("post clr b", CHK, 2, 6, 2, 1, 0, 0, 9'h000, 2);
    run("post clr c", CHK, 4, 0, 7, 1, 0, 0, 9'h000, 2);
    run("post clr d", CHK, 5, 5, 9, 1, 0, 0, 9'h000, 2);
    run("post clr e", CHK, 7, 8, 3, 1, 0, 0, 9'h000, 2);
    run("post clr f", CHK, 8, 4, 1, 1, 0, 0, 9'h000, 2);

    run_model("pre rst", PLC, 0, 0, 1);
    Cmd_valid = 1'b1; Cmd_op = 2'(PLC);
    Row = 4'd3; Col = 4'd7; Value = 4'd4;
    @(posedge Clk); #1;
    Cmd_valid = 1'b0;
    Reset = 1'b0;
    seen = 0;
    #1;
    if (Rsp_valid) seen = 1;
    repeat (3) begin
      @(posedge Clk); #1;
      if (Rsp_valid) seen = 1;
    end
    Reset = 1'b1;
    m_reset();
    repeat (3) begin
      @(posedge Clk); #1;
      if (Rsp_valid) seen = 1;
    end
    chk("abort no rsp", seen, 0);
    chk("abort ready", int'(Cmd_ready), 1);
    chk("abort count", int'(Placed_count), 0);
    run_model("abort chk", CHK, 3, 7, 4);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 31);
      if (sel == 0)      op = CLR;
      else if (sel < 12) op = CHK;
      else if (sel < 22) op = PLC;
      else               op = REM;
      r = $urandom_range(0, 8);
      c = $urandom_range(0, 8);
      v = $urandom_range(1, 9);
      if ($urandom_range(0, 15) == 0) r = $urandom_range(0, 15);
      if ($urandom_range(0, 15) == 0) c = $urandom_range(0, 15);
      if ($urandom_range(0, 15) == 0) v = $urandom_range(0, 15);
      if (op == REM && placed.size() > 0 && $urandom_range(0, 1) == 1) begin
        sel = $urandom_range(0, placed.size() - 1);
        r = placed[sel].r; c = placed[sel].c; v = placed[sel].v;
      end
      m_step(op, r, c, v, dok, derr, dlat);
      run($sformatf("rnd%0d", n), op, r, c, v, dok, derr,
          m_cnt, m_mask, dlat);
      if (op == CLR) placed.delete();
      else if (op == PLC && dok) placed.push_back('{r, c, v});
      else if (op == REM && dok) begin
        for (int j = 0; j < placed.size(); j++)
          if (placed[j].r == r && placed[j].c == c && placed[j].v == v) begin
            placed.delete(j);
            break;
          end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sudoku_constraint_tracker.md
Name: sudoku_constraint_tracker

Overview:
- Bookkeeping stage directly downstream of the sudoku solver FSM; consumes its (Row, Col, value) stream.
- Holds per-row, per-column and per-3x3-box "value used" bitmaps for the 9x9 board.
- Answers conflict checks, commits or removes placements, and reports the candidate mask for a cell.
- Lets the solver's Check/Forward/Back states make constant-latency decisions instead of scanning 27 cells per step.

Parameters:
- N, 9, board dimension; only 9 is supported, because the box math is hard-coded for 3x3 boxes.
- CNT_W, 7, width of the placed-cell counter (it must hold values up to 81).

Ports:
- Clk  in  1  system clock (100 MHz board clock).
- Reset  in  1  asynchronous, active-low reset.
- Cmd_valid  in  1  command request.
- Cmd_ready  out  1  tracker can accept a command this cycle.
- Cmd_op  in  2  00 CHECK, 01 PLACE, 10 REMOVE, 11 CLEAR.
- Row  in  4  cell row, 0-8.
- Col  in  4  cell column, 0-8.
- Value  in  4  digit, 1-9.
- Rsp_valid  out  1  one-cycle response strobe.
- Ok  out  1  result of the command; valid when Rsp_valid=1.
- Err  out  1  illegal operand; valid when Rsp_valid=1.
- Used_mask  out  9  bit k-1 set means digit k is present in the row, column or box of the last accepted cell.
- Placed_count  out  CNT_W  number of committed placements.

Behaviour:
- Reset (Reset=0, asynchronous):
  - All 27 masks are cleared.
  - Outputs go to Placed_count=0, Used_mask=0, Rsp_valid=0, Ok=0, Err=0, Cmd_ready=1.
  - The FSM goes to IDLE.
  - Reset asserted mid-command aborts the command with no response.
- FSM states:
  - IDLE: Cmd_ready=1. Cmd_valid=1 accepts the command at the clock edge. The op and operands are registered. Next state is DECODE, or CLR for CLEAR.
  - DECODE: Cmd_ready=0. Registers box = (Row/3)*3 + Col/3 using a compare-based divide (no divider). Registers Err_int = (Row>8) | (Col>8) | (Value==0) | (Value>9). Next state is EXEC.
  - EXEC: Cmd_ready=0. Reads row_mask[Row], col_mask[Col] and box_mask[box]. Performs the update below. At the clock edge it registers the response and returns to IDLE.
  - CLR: Cmd_ready=0. A 4-bit index counts 0..8 and clears row_mask[i], col_mask[i] and box_mask[i] once per cycle. After i=8 it sets Placed_count=0, responds with Ok=1, Err=0, and returns to IDLE.
- Latency:
  - Acceptance edge is E. Rsp_valid is high for exactly the cycle following edge E+2 for CHECK, PLACE and REMOVE.
  - For CLEAR, Rsp_valid follows edge E+10.
  - Cmd_ready returns to 1 in the same cycle Rsp_valid is high, so back-to-back commands are spaced 3 cycles apart.
- Command semantics (b = 1<<(Value-1)):
  - Err_int=1: Ok=0, Err=1, no state change, Used_mask unchanged.
  - CHECK: Ok=1 when b is absent from all three masks; no state change.
  - PLACE:
    - If b is absent from all three masks, set b in all three, increment Placed_count, Ok=1.
    - Otherwise Ok=0 and no change.
  - REMOVE:
    - If b is present in all three masks, clear b in all three, decrement Placed_count, Ok=1.
    - Otherwise Ok=0 and no change; a partial presence is treated as an inconsistency and nothing is cleared.
  - Used_mask is updated on every non-error response to the OR of the three masks after the update.
- Boundaries:
  - Placed_count saturates at 81 and never underflows below 0; both cases are unreachable under the rules above but must be guarded.
  - Cmd_valid is ignored while Cmd_ready=0, and operands may change freely then.
  - Cmd_op is sampled only at acceptance.
  - Ok and Err hold their values until the next response.

Test Plan:
- Release reset, PLACE (0,0,5) -> Rsp_valid 2 edges after accept; Ok=1, Err=0, Placed_count=1, Used_mask=9'h010.
- With (0,0,5) placed:
  - CHECK (0,8,5) -> Ok=0 (row conflict).
  - CHECK (8,0,5) -> Ok=0 (column conflict).
  - CHECK (2,2,5) -> Ok=0 (box 0 conflict).
  - CHECK (4,4,5) -> Ok=1.
- PLACE (1,1,5) after (0,0,5) -> Ok=0, Placed_count stays 1. Then REMOVE (0,0,5) -> Ok=1, Placed_count=0. Then PLACE (1,1,5) -> Ok=1.
- PLACE (9,0,3) -> Err=1, Ok=0. PLACE (3,3,0) -> Err=1. PLACE (3,3,10) -> Err=1. No count change in any case.
- Place 5 values, then CLEAR -> Cmd_ready low for 10 cycles; response Ok=1, Placed_count=0; CHECK of every previously placed value -> Ok=1.
- Assert Reset during DECODE of a PLACE -> no Rsp_valid; after release Cmd_ready=1, Placed_count=0, CHECK of the same cell/value -> Ok=1.
